csa_seq_accum: RTL and testbench

Sequential multi-operand adder that accepts N-bit operands one per cycle over a valid/ready stream and returns their sum. Each accepted operand is folded into a redundant carry/sum register pair by a single 3:2 carry-save row. After a group of OPERANDS operands, one ripple-carry pass resolves the pair into binary. It is the serial, streaming counterpart of the parallel 6-operand carry-save tree: it trades latency for one compressor row plus one carry-propagate adder, and sits between an operand producer stream and a result consumer.

---
 rtl/csa_seq_accum.sv | 143 ++++++++++++++
 tb/tb_csa_seq_accum.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/csa_seq_accum.sv
// Streaming multi-operand adder: one 3:2 carry-save row per accepted operand,
// then a single ripple-carry pass. Optional in_last port via CSA_ACC_LAST_EN.
module csa_seq_accum #(
    parameter int N        = 4,
    parameter int OPERANDS = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [N-1:0]                     in_data,
`ifdef CSA_ACC_LAST_EN
    input  logic                             in_last,
`endif
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N+$clog2(OPERANDS)-1:0]    out_sum
);

    localparam int W  = N + $clog2(OPERANDS);
    localparam int CW = $clog2(OPERANDS);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    function automatic logic [W-1:0] csa_sum(input logic [W-1:0] s, input logic [W-1:0] c,
                                             input logic [W-1:0] x);
        return s ^ c ^ x;
    endfunction

    function automatic logic [W-1:0] csa_carry(input logic [W-1:0] s, input logic [W-1:0] c,
                                               input logic [W-1:0] x);
        return ((s & c) | (s & x) | (c & x)) << 1;
    endfunction

    // The final carry-out is dropped: the width rule guarantees it is zero.
    function automatic logic [W-1:0] ripple_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        logic         c;
        c = 1'b0;
        for (int i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        return s;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_s;
    logic [W-1:0]    r_c;
    logic [W-1:0]    r_r;
    logic [CW-1:0]   r_cnt;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            w_accept;
    logic            w_group_end;
    logic [W-1:0]    w_x;

    assign w_x      = {{(W-N){1'b0}}, in_data};
    assign w_accept = in_valid && r_in_ready;

`ifdef CSA_ACC_LAST_EN
    assign w_group_end = (r_cnt == CW'(OPERANDS - 1)) || in_last;
`else
    assign w_group_end = (r_cnt == CW'(OPERANDS - 1));
`endif

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept && w_group_end) begin
                    w_state_nxt = ST_RESOLVE;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_RESOLVE: begin
                w_state_nxt = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_OUTPUT;
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
    end

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_ACCUM);
            r_out_valid <= (w_state_nxt == ST_OUTPUT);
        end
    end

    // Carry-save accumulation, resolve and result hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s   <= {W{1'b0}};
            r_c   <= {W{1'b0}};
            r_r   <= {W{1'b0}};
            r_cnt <= {CW{1'b0}};
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_s   <= csa_sum(r_s, r_c, w_x);
                        r_c   <= csa_carry(r_s, r_c, w_x);
                        r_cnt <= w_group_end ? {CW{1'b0}} : r_cnt + CW'(1);
                    end
                end
                ST_RESOLVE: begin
                    r_r <= ripple_add(r_s, r_c);
                    r_s <= {W{1'b0}};
                    r_c <= {W{1'b0}};
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_r;

endmodule

// File: tb/tb_csa_seq_accum.sv
// Directed bench for csa_seq_accum (N=4, OPERANDS=6, W=7).
module tb_csa_seq_accum;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_sum;
`ifdef CSA_ACC_LAST_EN
    logic       in_last;
`endif

    int n_cmp = 0;
    int n_err = 0;

    csa_seq_accum #(.N(4), .OPERANDS(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef CSA_ACC_LAST_EN
        .in_last   (in_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and hold it until it is accepted.
    task automatic send_op(input logic [3:0] d);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready) chk("rdy_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [6:0] exp);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(out_sum), 32'(exp));
        tick();
        chk({tag, "_vdrop"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [3:0] ops_a [6];
        ops_a = '{4'd9, 4'd0, 4'd7, 4'd15, 4'd1, 4'd8};
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b1;
`ifdef CSA_ACC_LAST_EN
        in_last   = 1'b0;
`endif
        tick();
        tick();
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_rdy0", 32'(in_ready), 32'd0);
        tick();
        chk("rel_rdy1", 32'(in_ready), 32'd1);

        // 1..6 back to back: RESOLVE cycle, then one cycle of out_valid.
        for (int i = 1; i <= 6; i++) send_op(4'(i));
        chk("t1_rdy_drop", 32'(in_ready), 32'd0);
        chk("t1_ov_resolve", 32'(out_valid), 32'd0);
        tick();
        chk("t1_ov", 32'(out_valid), 32'd1);
        chk("t1_sum", 32'(out_sum), 32'd21);
        chk("t1_rdy_out", 32'(in_ready), 32'd0);
        tick();
        chk("t1_ov_drop", 32'(out_valid), 32'd0);
        chk("t1_rdy_back", 32'(in_ready), 32'd1);

        for (int i = 0; i < 6; i++) send_op(4'd15);
        get_result("max", 7'd90);
        for (int i = 0; i < 6; i++) send_op(4'd0);
        get_result("zero", 7'd0);

        // Invalid cycles in between carry junk data that must be ignored.
        for (int i = 0; i < 6; i++) begin
            send_op(ops_a[i]);
            in_data = 4'hA;
            tick();
        end
        get_result("gap", 7'd40);

        // Backpressure: result holds while out_ready is low.
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send_op(4'(i));
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_ov", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(out_sum), 32'd21);
            chk("bp_rdy", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_sum_last", 32'(out_sum), 32'd21);
        tick();
        chk("bp_ov_drop", 32'(out_valid), 32'd0);
        chk("bp_rdy_back", 32'(in_ready), 32'd1);

        // Mid-group reset discards the partial sum.
        for (int i = 0; i < 3; i++) send_op(4'd5);
        rst = 1'b1;
        #1;
        chk("mr_rdy", 32'(in_ready), 32'd0);
        chk("mr_ov", 32'(out_valid), 32'd0);
        chk("mr_sum", 32'(out_sum), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) send_op(4'd1);
        get_result("after_rst", 7'd6);

`ifdef CSA_ACC_LAST_EN
        send_op(4'd3);
        in_last = 1'b1;
        send_op(4'd5);
        in_last = 1'b0;
        chk("last_rdy_drop", 32'(in_ready), 32'd0);
        tick();
        chk("last_ov", 32'(out_valid), 32'd1);
        get_result("last2", 7'd8);
        in_last = 1'b1;
        send_op(4'd12);
        in_last = 1'b0;
        get_result("last1", 7'd12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
